rgb_pwm_generator: RTL and testbench
====================================

Name: rgb_pwm_generator

Overview:
- Drives the on-board RGB LED from the three 8-bit on-time codes produced by the switch-to-colour decoder.
- Divides the system clock into PWM ticks, runs a shared 255-tick frame counter, and compares it against double-buffered per-channel duty codes.
- Duty codes are sampled only at frame boundaries, so switch changes never produce glitched or partial frames.
- Sits between the colour decoder and the LED pins.

Parameters:
- CLK_DIV, 16: system clocks per PWM tick; legal range 1..65535.
- ACTIVE_LOW, 0: 1 inverts all three PWM outputs for common-anode LEDs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  1 = run; 0 = hold and force LEDs off.
- R_time_in  input  8  red on-time code, 0x00 = off, 0xFF = fully on.
- G_time_in  input  8  green on-time code, same encoding.
- B_time_in  input  8  blue on-time code, same encoding.
- R_pwm  output  1  red PWM drive.
- G_pwm  output  1  green PWM drive.
- B_pwm  output  1  blue PWM drive.
- frame_start  output  1  one-clock pulse marking shadow reload / start of a new frame.

Behaviour:
- Reset (async assert, clk-synchronous release):
  - div_cnt=0, pwm_cnt=0, all shadows=0x00, first=1, frame_start=0.
  - R_pwm/G_pwm/B_pwm = ACTIVE_LOW (LEDs off).
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - tick=1 in the cycle div_cnt==CLK_DIV-1; div_cnt then wraps to 0.
  - CLK_DIV=1 gives tick every cycle.
- Frame counter:
  - pwm_cnt increments on tick and counts 0..254, then wraps to 0.
  - Frame length is exactly 255*CLK_DIV clocks.
- Reload condition: reload = en & (first | (tick & pwm_cnt==254)).
  - On a reload edge, each shadow register loads its *_time_in, and frame_start is registered to 1; otherwise frame_start=0.
  - first clears on the first clock edge with en=1.
  - Inputs are ignored at all other times; mid-frame input changes take effect at the next frame.
- Outputs:
  - Registered: X_pwm <= (pwm_cnt < X_shadow) ^ ACTIVE_LOW, an unsigned 8-bit compare.
  - One clock of latency from counter/shadow state to pin.
  - Code 0x00 never asserts; 0xFF asserts for the entire frame (255 of 255 ticks); code N asserts for N ticks = N*CLK_DIV clocks per frame.
- Steady state: outputs are high for a contiguous run starting at frame start; the duty edge at pwm_cnt==N is glitch-free.
- Disable (en=0):
  - div_cnt, pwm_cnt held at 0; first set to 1.
  - Outputs forced to ACTIVE_LOW on the next edge; frame_start=0; shadows retain their values.
  - Re-enable restarts a fresh frame with an immediate reload (first path).
- Simultaneous reload and input change: the shadow captures the input value present on that edge.
- Reset mid-frame: immediate async return to the reset state; the first frame after release starts with a reload, so there is no dead frame of zeros.

Test Plan:
- Reset/first frame: CLK_DIV=2, ACTIVE_LOW=0, inputs R=0x7F G=0x1F B=0xFF, rst pulse, en=1 → frame_start pulses 1 clk after release; R high 254 clks, G high 62 clks, B high all 510 clks per frame.
- Extremes: R=0x00, G=0xFF, B=0x01 → R constant 0, G constant 1, B high exactly CLK_DIV clocks at each frame start; frame_start period = 510 clks.
- Mid-frame change: R=0x7F; at pwm_cnt=10 set R=0x00 → current frame keeps 127-tick pulse; following frame R stays 0; change visible only after the frame_start pulse.
- Disable/re-enable: en=0 for 100 clks mid-frame → all outputs 0 within 1 clk, no frame_start; en=1 → frame_start 1 clk later, full fresh frame from pwm_cnt=0.
- Polarity: ACTIVE_LOW=1, R=0xFF G=0x00 B=0xFF → R=0, G=1, B=0 constant; during reset all outputs 1.
- Async reset mid-frame: assert rst between clock edges at pwm_cnt=100 → outputs at inactive level immediately, without waiting for a clock edge; after release, counts restart at 0.

Source files
------------

// File: rtl/rgb_pwm_generator.sv
// Three-channel PWM driver for an RGB LED: a shared prescaled 255-tick frame
// counter compared against per-channel duty codes captured only at frame boundaries.
module rgb_pwm_generator #(
  parameter int CLK_DIV    = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] R_time_in,
  input  logic [7:0] G_time_in,
  input  logic [7:0] B_time_in,
  output logic       R_pwm,
  output logic       G_pwm,
  output logic       B_pwm,
  output logic       frame_start
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'd254;
  localparam logic        OFF_LVL  = ACTIVE_LOW;

  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [2:0]      pwm_q, pwm_d;
  logic            first_q, first_d;
  logic            frame_start_q, frame_start_d;

  logic [2:0][7:0] time_in;
  logic            tick;
  logic            wrap;

  assign time_in = {B_time_in, G_time_in, R_time_in};

  always_comb begin
    tick          = (div_cnt_q == DIV_LAST);
    wrap          = tick && (pwm_cnt_q == CNT_LAST);
    div_cnt_d     = div_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    shadow_d      = shadow_q;
    pwm_d         = pwm_q;
    first_d       = first_q;
    frame_start_d = en && (first_q || wrap);

    if (!en) begin
      div_cnt_d = '0;
      pwm_cnt_d = '0;
      first_d   = 1'b1;
      pwm_d     = {3{OFF_LVL}};
    end else if (first_q) begin
      // Counters stay at 0 on the first reload so it lines up with a wrap
      // reload: the frame after either starts from count 0 and is 255*CLK_DIV long.
      first_d  = 1'b0;
      shadow_d = time_in;
      pwm_d    = {3{OFF_LVL}};
    end else begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
      if (tick) begin
        pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
      end
      for (int c = 0; c < 3; c++) begin
        pwm_d[c] = (pwm_cnt_q < shadow_q[c]) ^ OFF_LVL;
      end
      if (wrap) begin
        shadow_d = time_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      shadow_q      <= '0;
      pwm_q         <= {3{OFF_LVL}};
      first_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      pwm_q         <= pwm_d;
      first_q       <= first_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign R_pwm       = pwm_q[0];
  assign G_pwm       = pwm_q[1];
  assign B_pwm       = pwm_q[2];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_pwm_generator.sv
// Self-checking bench: two generator instances (CLK_DIV=2 active-high, CLK_DIV=3
// active-low) checked every cycle against a clock-position frame model.
module tb_rgb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] r_in = 8'h00, g_in = 8'h00, b_in = 8'h00;
  logic [2:0] pwm0, pwm1;
  logic       fs0, fs1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb_pwm_generator #(.CLK_DIV(2), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_pwm(pwm0[0]), .G_pwm(pwm0[1]), .B_pwm(pwm0[2]), .frame_start(fs0)
  );

  rgb_pwm_generator #(.CLK_DIV(3), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_pwm(pwm1[0]), .G_pwm(pwm1[1]), .B_pwm(pwm1[2]), .frame_start(fs1)
  );

  // Model: each instance is either idle or at clock position pos within a
  // 255*D-clock frame; a channel is on while pos/D is below its latched code.
  int         m_div[2] = '{2, 3};
  logic       m_al[2]  = '{1'b0, 1'b1};
  logic       m_idle[2];
  int         m_pos[2];
  logic [7:0] m_sh[2][3];
  logic [2:0] m_pwm[2];
  logic       m_fs[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_idle[i] <= 1'b1;
        m_pos[i]  <= 0;
        for (int c = 0; c < 3; c++) m_sh[i][c] <= 8'h00;
        m_pwm[i]  <= {3{m_al[i]}};
        m_fs[i]   <= 1'b0;
      end else if (!en) begin
        m_idle[i] <= 1'b1;
        m_pos[i]  <= 0;
        m_pwm[i]  <= {3{m_al[i]}};
        m_fs[i]   <= 1'b0;
      end else begin
        if (m_idle[i]) begin
          m_pwm[i] <= {3{m_al[i]}};
        end else begin
          for (int c = 0; c < 3; c++)
            m_pwm[i][c] <= ((m_pos[i] / m_div[i]) < int'(m_sh[i][c])) ^ m_al[i];
        end
        if (m_idle[i] || m_pos[i] == 255 * m_div[i] - 1) begin
          m_idle[i]  <= 1'b0;
          m_pos[i]   <= 0;
          m_sh[i][0] <= r_in;
          m_sh[i][1] <= g_in;
          m_sh[i][2] <= b_in;
          m_fs[i]    <= 1'b1;
        end else begin
          m_pos[i] <= m_pos[i] + 1;
          m_fs[i]  <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] a_pwm;
      logic       a_fs;
      a_pwm = (i == 0) ? pwm0 : pwm1;
      a_fs  = (i == 0) ? fs0 : fs1;
      for (int c = 0; c < 3; c++)
        check($sformatf("model_pwm i%0d ch%0d", i, c), int'(a_pwm[c]), int'(m_pwm[i][c]));
      check($sformatf("model_fs i%0d", i), int'(a_fs), int'(m_fs[i]));
    end
  end

  // Waits for the next frame_start of instance 0; n = negedges waited.
  task automatic wait_fs(output int n);
    n = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (fs0) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("wait_fs timeout", 0, 1);
  endtask

  // Counts instance-0 high samples over one 510-clock frame after a frame_start.
  task automatic measure(output int hr, output int hg, output int hb, output int fsk);
    hr = 0; hg = 0; hb = 0; fsk = 0;
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      hr += int'(pwm0[0]);
      hg += int'(pwm0[1]);
      hb += int'(pwm0[2]);
      if (fs0 && fsk == 0) fsk = k;
    end
  endtask

  initial begin
    int n, hr, hg, hb, fsk;

    #1 rst = 1'b1;
    r_in = 8'h7F; g_in = 8'h1F; b_in = 8'hFF;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pwm0", int'(pwm0), 0);
    check("reset pwm1", int'(pwm1), 7);
    check("reset fs0", int'(fs0), 0);

    // First frame after release.
    rst = 1'b0;
    @(negedge clk);
    check("fs one clk after release", int'(fs0), 1);
    measure(hr, hg, hb, fsk);
    check("first R high", hr, 254);
    check("first G high", hg, 62);
    check("first B high", hb, 510);
    check("frame period", fsk, 510);

    // Extremes.
    r_in = 8'h00; g_in = 8'hFF; b_in = 8'h01;
    wait_fs(n);
    check("period before extremes", n, 510);
    measure(hr, hg, hb, fsk);
    check("ext R high", hr, 0);
    check("ext G high", hg, 510);
    check("ext B high", hb, 2);
    check("ext period", fsk, 510);

    // Mid-frame change: loaded 0x7F frame keeps its full pulse.
    r_in = 8'h7F;
    wait_fs(n);
    repeat (20) @(negedge clk);
    r_in = 8'h00;
    hr = 0;
    for (int k = 0; k < 490; k++) begin
      @(negedge clk);
      hr += int'(pwm0[0]);
    end
    check("midframe R remainder", hr, 234);
    check("midframe fs at end", int'(fs0), 1);
    measure(hr, hg, hb, fsk);
    check("next frame R high", hr, 0);

    // Disable mid-frame, then re-enable.
    r_in = 8'hFF; g_in = 8'h80; b_in = 8'h40;
    wait_fs(n);
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("disabled pwm0", int'(pwm0), 0);
    check("disabled pwm1", int'(pwm1), 7);
    fsk = 0;
    for (int k = 0; k < 99; k++) begin
      @(negedge clk);
      fsk += int'(fs0);
    end
    check("no fs while disabled", fsk, 0);
    en = 1'b1;
    @(negedge clk);
    check("fs after re-enable", int'(fs0), 1);
    measure(hr, hg, hb, fsk);
    check("reenable R high", hr, 510);
    check("reenable G high", hg, 256);
    check("reenable B high", hb, 128);

    // Active-low instance: R=FF G=00 B=FF gives constant 0,1,0.
    r_in = 8'hFF; g_in = 8'h00; b_in = 8'hFF;
    repeat (1600) @(negedge clk);
    check("polarity pwm1", int'(pwm1), 3'b010);

    // Asynchronous reset between edges at roughly tick 100.
    r_in = 8'hC8; g_in = 8'hC8; b_in = 8'hC8;
    wait_fs(n);
    wait_fs(n);
    repeat (200) @(negedge clk);
    check("pre-reset pwm0 on", int'(pwm0), 7);
    #2 rst = 1'b1;
    #1;
    check("async reset pwm0", int'(pwm0), 0);
    check("async reset pwm1", int'(pwm1), 7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fs after async reset", int'(fs0), 1);
    measure(hr, hg, hb, fsk);
    check("post-reset R high", hr, 400);
    check("post-reset period", fsk, 510);

    // Randomized inputs and enable drops, checked by the model each cycle.
    for (int it = 0; it < 12; it++) begin
      r_in = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      g_in = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      b_in = 8'($urandom);
      repeat ($urandom_range(1, 900)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 50)) @(negedge clk);
        en = 1'b1;
      end
    end
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
